// File: rtl/muldiv_pkg.sv
// Shared constants for the RV32M multiply/divide engine: funct3 op codes,
// the M-extension funct7 and the FSM state encoding.
package muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam logic [6:0] FUNCT7_M  = 7'b0000001;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_CALC  = 2'b01,
    S_FIXUP = 2'b10,
    S_DONE  = 2'b11
  } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply or restoring shift-subtract
// divide over a 2*XLEN accumulator ({hi, lo}).
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   opnd,
  input  logic              is_div,
  output logic [2*XLEN-1:0] acc_nxt,
  output logic              q_bit
);

  logic [XLEN:0] sum;
  logic [XLEN:0] diff;

  always_comb begin
    sum     = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    // partial remainder shifted left with the next dividend bit, minus divisor
    diff    = acc[2*XLEN-1:XLEN-1] - {1'b0, opnd};
    q_bit   = 1'b0;
    acc_nxt = {sum, acc[XLEN-1:1]};
    if (is_div) begin
      q_bit   = ~diff[XLEN];
      acc_nxt = {(q_bit ? diff[XLEN-1:0] : acc[2*XLEN-2:XLEN-1]), acc[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide engine with pipeline stall request.
// Define MULDIV_FAST_MUL_EN for single-cycle combinational multiplies.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            stall_req,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  state_t            state, state_nxt;
  logic [2:0]        op_q;
  logic              neg_q;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opnd;

  logic              a_sgn, b_sgn, neg_in, is_div_in;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic              div_zero, ovf, fast_mul, fast_take;
  logic [XLEN-1:0]   mul_res, fast_res;
  logic [2*XLEN-1:0] step_acc, mul_fix;
  logic              step_q;
  logic [XLEN-1:0]   div_sel, fix_res;

  // operand decode for the instruction being accepted in IDLE
  always_comb begin
    is_div_in = funct3[2];
    a_sgn     = op_a[XLEN-1] & (funct3 inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
    b_sgn     = op_b[XLEN-1] & (funct3 inside {OP_MULH, OP_DIV, OP_REM});
    abs_a     = a_sgn ? -op_a : op_a;
    abs_b     = b_sgn ? -op_b : op_b;
    neg_in    = (funct3 == OP_REM) ? a_sgn : (a_sgn ^ b_sgn);
    div_zero  = is_div_in & (op_b == '0);
    ovf       = (funct3 inside {OP_DIV, OP_REM}) &
                (op_a == {1'b1, {(XLEN-1){1'b0}}}) & (op_b == '1);
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] sa, sb, prod;
  // low 2*XLEN bits of the sign-extended product equal the signed/mixed product
  assign sa       = {{XLEN{a_sgn}}, op_a};
  assign sb       = {{XLEN{b_sgn}}, op_b};
  assign prod     = sa * sb;
  assign fast_mul = ~funct3[2];
  assign mul_res  = (funct3 == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
`else
  assign fast_mul = 1'b0;
  assign mul_res  = '0;
`endif

  assign fast_take = div_zero | ovf | fast_mul;
  assign fast_res  = div_zero ? (funct3[1] ? op_a : '1) :
                     ovf      ? (funct3[1] ? '0 : op_a) : mul_res;

  muldiv_step #(.XLEN(XLEN)) u_step (
    .acc    (acc),
    .opnd   (opnd),
    .is_div (op_q[2]),
    .acc_nxt(step_acc),
    .q_bit  (step_q)
  );

  always_comb begin
    mul_fix = neg_q ? -acc : acc;
    div_sel = op_q[1] ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
    if (op_q[2])              fix_res = neg_q ? -div_sel : div_sel;
    else if (op_q == OP_MUL)  fix_res = mul_fix[XLEN-1:0];
    else                      fix_res = mul_fix[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start && !flush) state_nxt = fast_take ? S_DONE : S_CALC;
      S_CALC:  if (flush) state_nxt = S_IDLE;
               else if (cnt == '0) state_nxt = S_FIXUP;
      S_FIXUP: state_nxt = flush ? S_IDLE : S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q   <= '0;
      neg_q  <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      result <= '0;
    end else begin
      unique case (state)
        S_IDLE: if (start && !flush) begin
          op_q  <= funct3;
          neg_q <= neg_in;
          cnt   <= CW'(XLEN-1);
          // divide: lo holds the dividend; multiply: lo holds the multiplier
          acc   <= {{XLEN{1'b0}}, is_div_in ? abs_a : abs_b};
          opnd  <= is_div_in ? abs_b : abs_a;
          if (fast_take) result <= fast_res;
        end
        S_CALC: if (!flush) begin
          acc <= {step_acc[2*XLEN-1:1], op_q[2] ? step_q : step_acc[0]};
          cnt <= cnt - CW'(1);
        end
        S_FIXUP: if (!flush) result <= fix_res;
        default: ;
      endcase
    end
  end

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign stall_req = (state == S_CALC) | (state == S_FIXUP) |
                     ((state == S_IDLE) & start & ~flush);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table plus flush and reset sequences.
module tb_muldiv_unit;
  import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
  localparam int LM = 1;
`else
  localparam int LM = 34;
`endif
  localparam int LN = 34;

  logic        clk = 0, rst = 1, start = 0, flush = 0;
  logic [2:0]  funct3 = '0;
  logic [31:0] op_a = '0, op_b = '0;
  logic        stall_req, busy, done;
  logic [31:0] result;

  int checks = 0, failures = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .stall_req(stall_req), .busy(busy),
    .done(done), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a, b, exp;
    int          lat;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(logic [2:0] f, logic [31:0] a, logic [31:0] b,
                              logic [31:0] e, int l);
    vec_t v;
    v.f = f; v.a = a; v.b = b; v.exp = e; v.lat = l;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Drives one op, holds start until done; returns result, done latency and
  // whether stall_req was high every cycle before done and low in the done cycle.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output bit stall_ok);
    @(negedge clk);
    start = 1; funct3 = f; op_a = a; op_b = b;
    #1 stall_ok = stall_req;
    @(posedge clk);
    lat = 0; res = 'x;
    for (int k = 1; k <= 60; k++) begin
      #1;
      if (done) begin
        lat = k; res = result;
        stall_ok = stall_ok & !stall_req;
        break;
      end
      stall_ok = stall_ok & stall_req;
      @(posedge clk);
    end
    start = 0;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] res, prev;
  int          lat;
  bit          sok, seen;

  initial begin
    vecs[0]  = mk(OP_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, LM);
    vecs[1]  = mk(OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, LM);
    vecs[2]  = mk(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LM);
    vecs[3]  = mk(OP_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, LM);
    vecs[4]  = mk(OP_MUL,    32'd6,         32'd7,         32'd42,        LM);
    vecs[5]  = mk(OP_DIVU,   32'd100,       32'd7,         32'd14,        LN);
    vecs[6]  = mk(OP_REMU,   32'd100,       32'd7,         32'd2,         LN);
    vecs[7]  = mk(OP_DIV,    32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, LN);
    vecs[8]  = mk(OP_REM,    32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFFE, LN);
    vecs[9]  = mk(OP_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, 1);
    vecs[10] = mk(OP_REM,    32'd5,         32'd0,         32'd5,         1);
    vecs[11] = mk(OP_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 1);
    vecs[12] = mk(OP_REMU,   32'd9,         32'd0,         32'd9,         1);
    vecs[13] = mk(OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    vecs[14] = mk(OP_DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         LN);
    vecs[15] = mk(OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);

    #12;
    chk("reset_busy", {31'd0, busy}, 0);
    chk("reset_stall", {31'd0, stall_req}, 0);
    chk("reset_done", {31'd0, done}, 0);
    chk("reset_result", result, 0);
    @(negedge clk) rst = 0;

    for (int i = 0; i < 16; i++) begin
      run_op(vecs[i].f, vecs[i].a, vecs[i].b, res, lat, sok);
      chk($sformatf("vec%0d_result", i), res, vecs[i].exp);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("vec%0d_stall", i), {31'd0, sok}, 1);
      chk($sformatf("vec%0d_idle_after", i), {31'd0, busy}, 0);
    end
    prev = vecs[15].exp;

    // run a nonzero-result op so the flush check of result is meaningful
    run_op(OP_DIVU, 32'd100, 32'd7, res, lat, sok);
    prev = 32'd14;
    chk("pre_flush_result", res, prev);

    // flush 10 cycles into a DIV
    @(negedge clk);
    start = 1; funct3 = OP_DIV; op_a = 32'd1000; op_b = 32'd3;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1; start = 0;
    @(posedge clk); #1;
    chk("flush_busy", {31'd0, busy}, 0);
    chk("flush_done", {31'd0, done}, 0);
    chk("flush_result", result, prev);
    @(negedge clk) flush = 0;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen = 1;
    end
    chk("flush_no_done", {31'd0, seen}, 0);
    chk("flush_result_hold", result, prev);

    run_op(OP_MUL, 32'd3, 32'd4, res, lat, sok);
    chk("post_flush_mul", res, 32'd12);
    chk("post_flush_lat", lat, LM);

    // async reset in the middle of a divide
    @(negedge clk);
    start = 1; funct3 = OP_DIVU; op_a = 32'd999; op_b = 32'd5;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #2 rst = 1; start = 0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 0);
    chk("midrst_stall", {31'd0, stall_req}, 0);
    chk("midrst_done", {31'd0, done}, 0);
    chk("midrst_result", result, 0);
    @(negedge clk) rst = 0;

    run_op(OP_REMU, 32'd100, 32'd7, res, lat, sok);
    chk("post_rst_remu", res, 32'd2);
    chk("post_rst_lat", lat, LN);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
